i2c_master_arbiter: RTL and testbench
=====================================

// Module: i2c_master_arbiter
// PURPOSE
//  Shares one I2CMASTER byte interface (DEVICE 8'h68) between two command sequencers.
//  Example sequencers: the MPU6050 register scanner and a second sensor/config sequencer.
//  Grants the master to one client per transaction, round-robin; muxes commands, routes status.
//  Recovers the bus with a watchdog. Sits between the sequencers and I2CMASTER in the top level.
// PARAMETERS
//  TIMEOUT_TICS  255  TIC periods an owner may go without master activity before forced release (1..255)
// PORTS
//  MCLK          in   1   system clock
//  RESET         in   1   synchronous, active-high reset
//  TIC           in   1   one-MCLK strobe shared with I2CMASTER; all bus-side timing counts in TICs
//  REQ           in   2   client k requests ownership; held high for the whole transaction
//  GNT           out  2   one-hot (or 0) ownership grant
//  C_SRST        in   2   per-client soft reset for the master
//  C_DIN         in   16  per-client byte to send; client k uses bits [8k+7:8k]
//  C_RD          in   2   per-client read command
//  C_WE          in   2   per-client write command
//  C_QUEUED      out  2   master QUEUED, routed to owner only
//  C_NACK        out  2   master NACK, routed to owner only
//  C_STOP        out  2   master STOP, routed to owner only
//  C_DATA_VALID  out  2   master DATA_VALID, routed to owner only
//  C_DOUT        out  8   master read byte, broadcast (qualify with C_DATA_VALID)
//  M_SRST        out  1   to I2CMASTER SRST
//  M_DIN         out  8   to I2CMASTER DIN
//  M_RD          out  1   to I2CMASTER RD
//  M_WE          out  1   to I2CMASTER WE
//  M_QUEUED/M_NACK/M_STOP/M_DATA_VALID  in  1 each  from I2CMASTER
//  M_DOUT        in   8   from I2CMASTER DOUT
//  OWNER         out  1   index of current/last owner
//  BUSY          out  1   high in OWN and FLUSH
//  TIMEOUT       out  1   one-MCLK pulse when the watchdog forces a release
// BEHAVIOUR
//  Reset:
//   - state IDLE; GNT=0, OWNER=1 so client 0 wins first tie; BUSY=0, TIMEOUT=0.
//   - M_SRST=1 until first IDLE cycle, M_RD=M_WE=0, M_DIN=0, C_*=0; watchdog=0.
//   - RESET mid-transaction aborts immediately with these values.
//  FSM (evaluated every MCLK):
//   - IDLE: if REQ!=0, pick winner: sole requester, or on tie the client != OWNER.
//     Next cycle: OWN, GNT[winner]=1, OWNER=winner. Arbitration latency 1 MCLK.
//   - OWN: M_SRST/M_DIN/M_RD/M_WE = owner's inputs, combinational pass-through.
//     Master status goes to owner's C_* bit; the non-owner's C_* bits stay 0.
//     Exit when REQ[OWNER]=0 or the watchdog expires -> FLUSH; GNT drops that same cycle.
//   - FLUSH: M_RD=M_WE=0, M_SRST=1 until the next TIC inclusive, then IDLE.
//     The master always returns to idle before the next owner.
//  Other rules:
//   - Non-owner commands are ignored entirely; GNT is never two-hot.
//   - A client never gains GNT in the same cycle another loses it.
//   - Watchdog, OWN only: reset to 0 on GNT and on any TIC-qualified M_QUEUED/M_DATA_VALID/M_STOP.
//     Otherwise +1 per TIC; saturates; expiry at count == TIMEOUT_TICS.
//     On expiry, TIMEOUT pulses one cycle and the state goes to FLUSH.
//   - M_NACK is routed only; it does not force release (owner decides).
//   - REQ dropping in IDLE/FLUSH has no effect; REQ rising during FLUSH waits for IDLE.
//   - OWNER updates only on grant.
// TESTING
//  - Reset, REQ=01 -> GNT=01 one MCLK later, OWNER=0; C_WE[0]=1 appears on M_WE same cycle.
//  - REQ=11 from reset -> client0 granted; on drop of REQ[0]: FLUSH (M_SRST=1 through next TIC), then GNT=10.
//  - Owner 0, C_WE[1]=1, C_DIN[15:8]=8'hA5 -> M_WE=0, M_DIN=owner byte; M_QUEUED pulse -> C_QUEUED=01 only.
//  - TIMEOUT_TICS=4, owner silent -> TIMEOUT pulse on 4th TIC, GNT=00, FLUSH, then IDLE.
//  - Owner 1 read: M_DATA_VALID with M_DOUT=8'h3C -> C_DATA_VALID=10, C_DOUT=8'h3C; M_NACK -> C_NACK=10, GNT kept.
//  - RESET asserted in OWN mid-byte -> next cycle GNT=00, M_SRST=1, BUSY=0, M_RD=M_WE=0.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2CMASTER byte interface between two command sequencers,
// with a TIC-based watchdog that forces release of a silent owner and a flush through master soft reset.
module i2c_master_arbiter #(
  parameter int unsigned TIMEOUT_TICS = 255
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        TIC,
  input  logic [1:0]  REQ,
  output logic [1:0]  GNT,
  input  logic [1:0]  C_SRST,
  input  logic [15:0] C_DIN,
  input  logic [1:0]  C_RD,
  input  logic [1:0]  C_WE,
  output logic [1:0]  C_QUEUED,
  output logic [1:0]  C_NACK,
  output logic [1:0]  C_STOP,
  output logic [1:0]  C_DATA_VALID,
  output logic [7:0]  C_DOUT,
  output logic        M_SRST,
  output logic [7:0]  M_DIN,
  output logic        M_RD,
  output logic        M_WE,
  input  logic        M_QUEUED,
  input  logic        M_NACK,
  input  logic        M_STOP,
  input  logic        M_DATA_VALID,
  input  logic [7:0]  M_DOUT,
  output logic        OWNER,
  output logic        BUSY,
  output logic        TIMEOUT
);

  localparam logic [7:0] LP_TIMEOUT = TIMEOUT_TICS[7:0];

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_FLUSH} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_owner;
  logic [7:0] r_wd;
  logic       r_rst_hold;

  logic       w_winner;
  logic       w_act;
  logic [7:0] w_wd_inc;
  logic       w_expire;
  logic       w_exit;

  // On a tie the client that did not own last time wins.
  always_comb begin
    w_winner = ~r_owner;
    if (REQ == 2'b01)      w_winner = 1'b0;
    else if (REQ == 2'b10) w_winner = 1'b1;
  end

  assign w_act    = TIC & (M_QUEUED | M_DATA_VALID | M_STOP);
  assign w_wd_inc = (r_wd == '1) ? r_wd : r_wd + 8'd1;
  // Expiry is decided on the TIC that would bring the count to the limit, so release coincides with that TIC.
  assign w_expire = (r_state == S_OWN) && TIC && !w_act && (w_wd_inc == LP_TIMEOUT);
  assign w_exit   = (r_state == S_OWN) && (!REQ[r_owner] || w_expire);

  // State register and watchdog/owner datapath
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b1;
      r_wd       <= '0;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_rst_hold <= 1'b0;
      if (r_state == S_IDLE && w_next == S_OWN) begin
        r_owner <= w_winner;
        r_wd    <= '0;
      end else if (r_state == S_OWN) begin
        if (w_act)    r_wd <= '0;
        else if (TIC) r_wd <= w_wd_inc;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (REQ != 2'b00) w_next = S_OWN;
      S_OWN:   if (w_exit)       w_next = S_FLUSH;
      S_FLUSH: if (TIC)          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    GNT          = '0;
    C_QUEUED     = '0;
    C_NACK       = '0;
    C_STOP       = '0;
    C_DATA_VALID = '0;
    C_DOUT       = '0;
    M_SRST       = 1'b0;
    M_DIN        = '0;
    M_RD         = 1'b0;
    M_WE         = 1'b0;
    TIMEOUT      = 1'b0;
    case (r_state)
      S_IDLE: M_SRST = r_rst_hold;
      S_OWN: begin
        GNT[r_owner]          = ~w_exit;
        M_SRST                = C_SRST[r_owner];
        M_DIN                 = r_owner ? C_DIN[15:8] : C_DIN[7:0];
        M_RD                  = C_RD[r_owner];
        M_WE                  = C_WE[r_owner];
        C_QUEUED[r_owner]     = M_QUEUED;
        C_NACK[r_owner]       = M_NACK;
        C_STOP[r_owner]       = M_STOP;
        C_DATA_VALID[r_owner] = M_DATA_VALID;
        C_DOUT                = M_DOUT;
        TIMEOUT               = w_expire;
      end
      S_FLUSH: M_SRST = 1'b1;
      default: M_SRST = 1'b1;
    endcase
  end

  assign OWNER = r_owner;
  assign BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: grant, round-robin, flush, routing, watchdog and reset abort.
module tb_i2c_master_arbiter;

  logic        MCLK = 1'b0;
  logic        RESET, TIC;
  logic [1:0]  REQ, GNT, C_SRST, C_RD, C_WE;
  logic [15:0] C_DIN;
  logic [1:0]  C_QUEUED, C_NACK, C_STOP, C_DATA_VALID;
  logic [7:0]  C_DOUT, M_DIN, M_DOUT;
  logic        M_SRST, M_RD, M_WE;
  logic        M_QUEUED, M_NACK, M_STOP, M_DATA_VALID;
  logic        OWNER, BUSY, TIMEOUT;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  always #5 MCLK = ~MCLK;

  i2c_master_arbiter #(.TIMEOUT_TICS(4)) dut (
    .MCLK(MCLK), .RESET(RESET), .TIC(TIC), .REQ(REQ), .GNT(GNT),
    .C_SRST(C_SRST), .C_DIN(C_DIN), .C_RD(C_RD), .C_WE(C_WE),
    .C_QUEUED(C_QUEUED), .C_NACK(C_NACK), .C_STOP(C_STOP),
    .C_DATA_VALID(C_DATA_VALID), .C_DOUT(C_DOUT),
    .M_SRST(M_SRST), .M_DIN(M_DIN), .M_RD(M_RD), .M_WE(M_WE),
    .M_QUEUED(M_QUEUED), .M_NACK(M_NACK), .M_STOP(M_STOP),
    .M_DATA_VALID(M_DATA_VALID), .M_DOUT(M_DOUT),
    .OWNER(OWNER), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; TIC = 1'b0; REQ = '0; C_SRST = '0; C_DIN = '0; C_RD = '0; C_WE = '0;
    M_QUEUED = 1'b0; M_NACK = 1'b0; M_STOP = 1'b0; M_DATA_VALID = 1'b0; M_DOUT = '0;
    tick(); tick();
    chk("rst_gnt",     16'(GNT),     16'h0);
    chk("rst_owner",   16'(OWNER),   16'h1);
    chk("rst_busy",    16'(BUSY),    16'h0);
    chk("rst_timeout", 16'(TIMEOUT), 16'h0);
    chk("rst_srst",    16'(M_SRST),  16'h1);
    chk("rst_mwe",     16'(M_WE),    16'h0);
    chk("rst_mdin",    16'(M_DIN),   16'h0);
    RESET = 1'b0;
    tick();
    chk("idle_srst",   16'(M_SRST),  16'h0);

    // Single requester: grant one cycle later, write passes through
    REQ = 2'b01; C_WE = 2'b01; C_DIN = 16'h0012;
    #1 chk("arb_latency", 16'(GNT), 16'h0);
    tick();
    chk("g0_gnt",   16'(GNT),   16'h1);
    chk("g0_owner", 16'(OWNER), 16'h0);
    chk("g0_busy",  16'(BUSY),  16'h1);
    chk("g0_mwe",   16'(M_WE),  16'h1);
    chk("g0_mdin",  16'(M_DIN), 16'h12);

    // Non-owner command ignored, status routed to owner only
    C_WE = 2'b10; C_DIN = 16'hA512; M_QUEUED = 1'b1;
    #1;
    chk("nonown_mwe",  16'(M_WE),     16'h0);
    chk("nonown_mdin", 16'(M_DIN),    16'h12);
    chk("queued_rt",   16'(C_QUEUED), 16'h1);
    tick();
    M_QUEUED = 1'b0;

    // Release by dropping REQ[0] while client 1 waits
    REQ = 2'b10;
    #1 chk("drop_gnt", 16'(GNT), 16'h0);
    tick();
    chk("fl_busy", 16'(BUSY),   16'h1);
    chk("fl_srst", 16'(M_SRST), 16'h1);
    chk("fl_mwe",  16'(M_WE),   16'h0);
    chk("fl_gnt",  16'(GNT),    16'h0);
    tick();
    chk("fl_hold_srst", 16'(M_SRST), 16'h1);
    TIC = 1'b1;
    #1 chk("fl_tic_srst", 16'(M_SRST), 16'h1);
    tick();
    TIC = 1'b0;
    chk("fl_idle_busy", 16'(BUSY), 16'h0);
    chk("fl_idle_gnt",  16'(GNT),  16'h0);
    tick();
    chk("g1_gnt",   16'(GNT),   16'h2);
    chk("g1_owner", 16'(OWNER), 16'h1);
    chk("g1_mwe",   16'(M_WE),  16'h1);

    // Owner 1 read data and NACK routing
    C_WE = 2'b00; C_RD = 2'b10; M_DATA_VALID = 1'b1; M_DOUT = 8'h3C; M_NACK = 1'b1;
    #1;
    chk("g1_mrd",  16'(M_RD),         16'h1);
    chk("dv_rt",   16'(C_DATA_VALID), 16'h2);
    chk("dout_rt", 16'(C_DOUT),       16'h3C);
    chk("nack_rt", 16'(C_NACK),       16'h2);
    tick();
    M_DATA_VALID = 1'b0; M_NACK = 1'b0; C_RD = 2'b00;
    chk("nack_keep", 16'(GNT), 16'h2);

    // Watchdog: silent owner, expiry on the 4th TIC
    for (int i = 0; i < 3; i++) begin
      TIC = 1'b1; tick();
      TIC = 1'b0; tick();
    end
    chk("wd_pre_gnt", 16'(GNT),     16'h2);
    chk("wd_pre_to",  16'(TIMEOUT), 16'h0);
    TIC = 1'b1;
    #1;
    chk("wd_to",     16'(TIMEOUT), 16'h1);
    chk("wd_gnt",    16'(GNT),     16'h0);
    tick();
    TIC = 1'b0;
    #1;
    chk("wd_to_end", 16'(TIMEOUT), 16'h0);
    chk("wd_flush",  16'(M_SRST),  16'h1);
    REQ = 2'b11; TIC = 1'b1;
    tick();
    TIC = 1'b0;
    chk("wd_idle", 16'(BUSY), 16'h0);
    tick();
    chk("tie_gnt",   16'(GNT),   16'h1);
    chk("tie_owner", 16'(OWNER), 16'h0);

    // Reset mid-transaction
    C_WE = 2'b01; C_RD = 2'b01;
    #1 chk("pre_rst_mwe", 16'(M_WE), 16'h1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mrst_gnt",   16'(GNT),    16'h0);
    chk("mrst_srst",  16'(M_SRST), 16'h1);
    chk("mrst_busy",  16'(BUSY),   16'h0);
    chk("mrst_mwe",   16'(M_WE),   16'h0);
    chk("mrst_mrd",   16'(M_RD),   16'h0);
    chk("mrst_owner", 16'(OWNER),  16'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
